// File: rtl/interrupt_controller.sv
// interrupt_controller
//   Memory-mapped interrupt controller between the I/O devices and the CPU's
//   single interrupt input. Rising edges on IRQIN are captured into PEND,
//   filtered by MASK and the global enable, and arbitrated by fixed or
//   rotating priority. One winner at a time is presented to the CPU through
//   the IRQ / INTA / EOI handshake.
//
// Ports
//   CLK      system clock, all state on the rising edge
//   RESET    asynchronous, active-low reset
//   ADDRBUS  processor address
//   DATABUS  processor data; driven only on reads of this block, else Z
//   WE       write enable for the current bus access
//   IRQIN    level IRQ lines from devices (index 0 = timer), synchronous to CLK
//   INTA     one-cycle interrupt-acknowledge pulse from the CPU
//   IRQ      interrupt request to the CPU (registered)
//   IRQID    ID of the source currently asserted or in service
//
// Register map
//   BASE      PEND  read: pending bits, write: W1C (a same-cycle new edge wins)
//   MASKBASE  MASK  read/write, bit i enables source i
//   IDBASE    ID    read: {valid, IRQID}, write: end of interrupt (data ignored)
//   CTRLBASE  CTRL  bit0 GIE, bit1 ROT
module interrupt_controller #(
  parameter int              BITS     = 32,
  parameter int              NSRC     = 4,
  parameter int              IDBITS   = 2,
  parameter logic [BITS-1:0] BASE     = 32'hFFFF0400,
  parameter logic [BITS-1:0] MASKBASE = BASE + BITS'(4),
  parameter logic [BITS-1:0] IDBASE   = BASE + BITS'(8),
  parameter logic [BITS-1:0] CTRLBASE = BASE + BITS'(12)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [BITS-1:0]   ADDRBUS,
  inout  wire  [BITS-1:0]   DATABUS,
  input  logic              WE,
  input  logic [NSRC-1:0]   IRQIN,
  input  logic              INTA,
  output logic              IRQ,
  output logic [IDBITS-1:0] IRQID
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t            state;
  logic [NSRC-1:0]   pend;
  logic [NSRC-1:0]   mask;
  logic [NSRC-1:0]   prev_irqin;
  logic              gie;
  logic              rot;
  logic [IDBITS-1:0] rot_ptr;

  logic              sel_pend, sel_mask, sel_id, sel_ctrl;
  logic              wr_pend, wr_mask, wr_id, wr_ctrl;
  logic              rd_en;
  logic [BITS-1:0]   rdata;
  logic [NSRC-1:0]   rise;
  logic [NSRC-1:0]   elig;
  logic [NSRC-1:0]   ack_clr;
  logic [NSRC-1:0]   w1c_clr;
  logic [IDBITS-1:0] search_start;
  logic [IDBITS-1:0] winner;
  logic              ack;

  // First eligible source found when scanning upward from 'start', wrapping
  // modulo NSRC. With start = 0 this is plain lowest-index-wins.
  function automatic logic [IDBITS-1:0] pick_winner(
    input logic [NSRC-1:0]   vec,
    input logic [IDBITS-1:0] start
  );
    logic [IDBITS-1:0] w;
    logic              found;
    int                idx;
    w     = '0;
    found = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      idx = (int'(start) + i) % NSRC;
      if (!found && vec[idx]) begin
        w     = IDBITS'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  // Address decode
  assign sel_pend = (ADDRBUS == BASE);
  assign sel_mask = (ADDRBUS == MASKBASE);
  assign sel_id   = (ADDRBUS == IDBASE);
  assign sel_ctrl = (ADDRBUS == CTRLBASE);

  assign wr_pend = WE & sel_pend;
  assign wr_mask = WE & sel_mask;
  assign wr_id   = WE & sel_id;
  assign wr_ctrl = WE & sel_ctrl;
  assign rd_en   = ~WE & (sel_pend | sel_mask | sel_id | sel_ctrl);

  // Arbitration
  assign rise         = IRQIN & ~prev_irqin;
  assign elig         = gie ? (pend & mask) : '0;
  assign search_start = rot ? rot_ptr : '0;
  assign winner       = pick_winner(elig, search_start);

  // The ack is only honoured while the latched winner is still eligible;
  // otherwise the controller withdraws the request instead.
  assign ack     = (state == S_ASSERT) && elig[IRQID] && INTA;
  assign ack_clr = ack ? (NSRC'(1) << IRQID) : '0;
  assign w1c_clr = wr_pend ? DATABUS[NSRC-1:0] : '0;

  // Read mux
  always_comb begin
    rdata = '0;
    if (sel_pend) rdata = BITS'(pend);
    if (sel_mask) rdata = BITS'(mask);
    if (sel_id)   rdata = BITS'({(state == S_SERVICE), IRQID});
    if (sel_ctrl) rdata = BITS'({rot, gie});
  end

  assign DATABUS = rd_en ? rdata : 'z;

  // Registers: edge capture and bus-writable state. Clears are applied
  // before sets so a new edge in the same cycle is never lost.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      prev_irqin <= '0;
      pend       <= '0;
      mask       <= '0;
      gie        <= 1'b0;
      rot        <= 1'b0;
    end else begin
      prev_irqin <= IRQIN;
      pend       <= (pend & ~w1c_clr & ~ack_clr) | rise;
      if (wr_mask) mask <= DATABUS[NSRC-1:0];
      if (wr_ctrl) begin
        gie <= DATABUS[0];
        rot <= DATABUS[1];
      end
    end
  end

  // Handshake FSM with registered IRQ / IRQID
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state   <= S_IDLE;
      IRQ     <= 1'b0;
      IRQID   <= '0;
      rot_ptr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|elig) begin
            IRQID <= winner;
            IRQ   <= 1'b1;
            state <= S_ASSERT;
          end
        end
        S_ASSERT: begin
          // A higher-priority arrival does not preempt; only loss of
          // eligibility of the latched winner pulls the request back.
          if (!elig[IRQID]) begin
            IRQ   <= 1'b0;
            state <= S_IDLE;
          end else if (INTA) begin
            IRQ   <= 1'b0;
            state <= S_SERVICE;
          end
        end
        S_SERVICE: begin
          if (wr_id) begin
            rot_ptr <= IDBITS'((int'(IRQID) + 1) % NSRC);
            state   <= S_IDLE;
          end
        end
        default: begin
          IRQ   <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Testbench for interrupt_controller: scenario tasks drive the bus, IRQIN
// and INTA; expected values are queued when stimulus is applied and popped
// when the corresponding DUT output is sampled.
module tb_interrupt_controller;

  localparam logic [31:0] A_PEND = 32'hFFFF0400;
  localparam logic [31:0] A_MASK = 32'hFFFF0404;
  localparam logic [31:0] A_ID   = 32'hFFFF0408;
  localparam logic [31:0] A_CTRL = 32'hFFFF040C;
  localparam logic [31:0] A_NONE = 32'h00001000;

  logic        CLK     = 1'b0;
  logic        RESET   = 1'b0;
  logic        WE      = 1'b0;
  logic        INTA    = 1'b0;
  logic [31:0] ADDRBUS = A_NONE;
  logic [3:0]  IRQIN   = 4'b0;
  wire  [31:0] DATABUS;
  logic        IRQ;
  logic [1:0]  IRQID;

  logic [31:0] dbus_drv = 32'h0;
  logic        drv_en   = 1'b0;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;
  logic [31:0] rd;
  logic [31:0] obs;

  assign DATABUS = drv_en ? dbus_drv : 'z;

  interrupt_controller dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .ADDRBUS (ADDRBUS),
    .DATABUS (DATABUS),
    .WE      (WE),
    .IRQIN   (IRQIN),
    .INTA    (INTA),
    .IRQ     (IRQ),
    .IRQID   (IRQID)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog expired got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    ADDRBUS  = a;
    dbus_drv = d;
    drv_en   = 1'b1;
    WE       = 1'b1;
    tick();
    WE      = 1'b0;
    drv_en  = 1'b0;
    ADDRBUS = A_NONE;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    ADDRBUS = a;
    WE      = 1'b0;
    #1;
    d       = DATABUS;
    ADDRBUS = A_NONE;
  endtask

  task automatic pulse_inta();
    INTA = 1'b1;
    tick();
    INTA = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    repeat (3) tick();
    RESET = 1'b1;
    tick();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'hzzzzzzzz);
    obs = {29'b0, IRQ, IRQID};
    exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_irq got %h want %h", obs, exp_v); end
    bus_read(A_PEND, rd); exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin errors++; $display("FAIL reset_pend got %h want %h", rd, exp_v); end
    bus_read(A_MASK, rd); exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin errors++; $display("FAIL reset_mask got %h want %h", rd, exp_v); end
    bus_read(A_CTRL, rd); exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin errors++; $display("FAIL reset_ctrl got %h want %h", rd, exp_v); end
    bus_read(A_NONE, rd); exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin errors++; $display("FAIL reset_bus_z got %h want %h", rd, exp_v); end
  endtask

  task automatic test_basic();
    bus_write(A_MASK, 32'hF);
    bus_write(A_CTRL, 32'h1);
    IRQIN = 4'b0100;
    exp_q.push_back(32'h4);               // PEND one cycle after the edge
    exp_q.push_back(32'h0);               // IRQ not yet up
    exp_q.push_back({29'b0, 1'b1, 2'd2}); // IRQ=1, IRQID=2 two cycles after
    tick();
    bus_read(A_PEND, rd); exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin errors++; $display("FAIL basic_pend got %h want %h", rd, exp_v); end
    obs = {31'b0, IRQ}; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL basic_irq_early got %h want %h", obs, exp_v); end
    IRQIN = 4'b0000;
    tick();
    obs = {29'b0, IRQ, IRQID}; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL basic_assert got %h want %h", obs, exp_v); end
    exp_q.push_back(32'h0);  // IRQ after ack
    exp_q.push_back(32'h0);  // PEND after ack
    exp_q.push_back(32'h6);  // ID in service
    exp_q.push_back(32'h2);  // ID after EOI
    pulse_inta();
    obs = {31'b0, IRQ}; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL basic_irq_ack got %h want %h", obs, exp_v); end
    bus_read(A_PEND, rd); exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin errors++; $display("FAIL basic_pend_ack got %h want %h", rd, exp_v); end
    bus_read(A_ID, rd); exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin errors++; $display("FAIL basic_id_service got %h want %h", rd, exp_v); end
    bus_write(A_ID, 32'h0);
    bus_read(A_ID, rd); exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin errors++; $display("FAIL basic_id_eoi got %h want %h", rd, exp_v); end
  endtask

  task automatic test_fixed_priority();
    IRQIN = 4'b1010;
    exp_q.push_back({29'b0, 1'b1, 2'd1});
    exp_q.push_back({29'b0, 1'b0, 2'd1});
    exp_q.push_back({29'b0, 1'b1, 2'd3});
    tick();
    IRQIN = 4'b0000;
    tick();
    obs = {29'b0, IRQ, IRQID}; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL fixed_first got %h want %h", obs, exp_v); end
    pulse_inta();
    bus_write(A_ID, 32'h0);
    obs = {29'b0, IRQ, IRQID}; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL fixed_at_eoi got %h want %h", obs, exp_v); end
    tick();
    obs = {29'b0, IRQ, IRQID}; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL fixed_second got %h want %h", obs, exp_v); end
    pulse_inta();
    bus_write(A_ID, 32'h0);
  endtask

  task automatic test_rotate();
    bus_write(A_CTRL, 32'h3);
    IRQIN = 4'b0001;
    exp_q.push_back({29'b0, 1'b1, 2'd0});
    tick();
    IRQIN = 4'b0000;
    tick();
    obs = {29'b0, IRQ, IRQID}; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL rot_src0 got %h want %h", obs, exp_v); end
    pulse_inta();
    bus_write(A_ID, 32'h0);  // pointer becomes 1
    IRQIN = 4'b0101;
    exp_q.push_back({29'b0, 1'b1, 2'd2});
    exp_q.push_back({29'b0, 1'b1, 2'd0});
    tick();
    IRQIN = 4'b0000;
    tick();
    obs = {29'b0, IRQ, IRQID}; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL rot_wins2 got %h want %h", obs, exp_v); end
    pulse_inta();
    bus_write(A_ID, 32'h0);  // pointer becomes 3, wraps to 0
    tick();
    obs = {29'b0, IRQ, IRQID}; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL rot_next0 got %h want %h", obs, exp_v); end
    pulse_inta();
    bus_write(A_ID, 32'h0);
    bus_write(A_CTRL, 32'h1);
  endtask

  task automatic test_withdraw();
    IRQIN = 4'b0010;
    exp_q.push_back({29'b0, 1'b1, 2'd1});
    tick();
    IRQIN = 4'b0000;
    tick();
    obs = {29'b0, IRQ, IRQID}; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL wd_assert got %h want %h", obs, exp_v); end
    bus_write(A_MASK, 32'hD);
    tick();
    exp_q.push_back(32'h0);  // IRQ withdrawn
    exp_q.push_back(32'h2);  // PEND[1] still set
    exp_q.push_back(32'h1);  // ID: not valid, IRQID 1
    obs = {31'b0, IRQ}; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL wd_irq got %h want %h", obs, exp_v); end
    bus_read(A_PEND, rd); exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin errors++; $display("FAIL wd_pend got %h want %h", rd, exp_v); end
    bus_read(A_ID, rd); exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin errors++; $display("FAIL wd_id got %h want %h", rd, exp_v); end
    bus_write(A_MASK, 32'hF);
    exp_q.push_back({29'b0, 1'b1, 2'd1});
    tick();
    obs = {29'b0, IRQ, IRQID}; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL wd_reassert got %h want %h", obs, exp_v); end
    pulse_inta();
    bus_write(A_ID, 32'h0);
  endtask

  task automatic test_boundaries();
    // INTA while idle is ignored
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h1);
    pulse_inta();
    obs = {31'b0, IRQ}; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL bnd_inta_idle_irq got %h want %h", obs, exp_v); end
    bus_read(A_ID, rd); exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin errors++; $display("FAIL bnd_inta_idle_id got %h want %h", rd, exp_v); end
    // EOI while asserting is ignored
    IRQIN = 4'b1000;
    exp_q.push_back({29'b0, 1'b1, 2'd3});
    tick();
    IRQIN = 4'b0000;
    tick();
    bus_write(A_ID, 32'h0);
    obs = {29'b0, IRQ, IRQID}; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL bnd_eoi_assert got %h want %h", obs, exp_v); end
    pulse_inta();
    bus_write(A_ID, 32'h0);
    // W1C of PEND[0] in the same cycle as a new IRQIN[0] edge
    bus_write(A_CTRL, 32'h0);
    IRQIN = 4'b0001;
    tick();
    IRQIN = 4'b0000;
    tick();
    IRQIN = 4'b0001;
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h0);
    bus_write(A_PEND, 32'h1);
    bus_read(A_PEND, rd); exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin errors++; $display("FAIL bnd_set_wins got %h want %h", rd, exp_v); end
    bus_write(A_PEND, 32'h1);
    bus_read(A_PEND, rd); exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin errors++; $display("FAIL bnd_w1c got %h want %h", rd, exp_v); end
    // A held-high level produces exactly one pending event
    IRQIN = 4'b0000;
    tick();
    IRQIN = 4'b0001;
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h0);
    repeat (10) tick();
    bus_read(A_PEND, rd); exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin errors++; $display("FAIL bnd_level_once got %h want %h", rd, exp_v); end
    bus_write(A_PEND, 32'h1);
    tick();
    bus_read(A_PEND, rd); exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin errors++; $display("FAIL bnd_level_no_retrig got %h want %h", rd, exp_v); end
    IRQIN = 4'b0000;
    tick();
    bus_write(A_CTRL, 32'h1);
  endtask

  task automatic test_reset_in_service();
    IRQIN = 4'b0100;
    tick();
    IRQIN = 4'b0000;
    tick();
    pulse_inta();
    IRQIN = 4'b0010;  // new edge recorded while in service
    tick();
    IRQIN = 4'b0000;
    exp_q.push_back(32'h6);
    exp_q.push_back(32'h2);
    bus_read(A_ID, rd); exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin errors++; $display("FAIL rst_pre_id got %h want %h", rd, exp_v); end
    bus_read(A_PEND, rd); exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin errors++; $display("FAIL rst_pre_pend got %h want %h", rd, exp_v); end
    RESET = 1'b0;
    #1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'hzzzzzzzz);
    obs = {29'b0, IRQ, IRQID}; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL rst_irq got %h want %h", obs, exp_v); end
    bus_read(A_PEND, rd); exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin errors++; $display("FAIL rst_pend got %h want %h", rd, exp_v); end
    bus_read(A_MASK, rd); exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin errors++; $display("FAIL rst_mask got %h want %h", rd, exp_v); end
    bus_read(A_CTRL, rd); exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin errors++; $display("FAIL rst_ctrl got %h want %h", rd, exp_v); end
    bus_read(A_ID, rd); exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin errors++; $display("FAIL rst_id got %h want %h", rd, exp_v); end
    bus_read(A_NONE, rd); exp_v = exp_q.pop_front(); checks++;
    if (rd !== exp_v) begin errors++; $display("FAIL rst_bus_z got %h want %h", rd, exp_v); end
    tick();
    RESET = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fixed_priority();
    test_rotate();
    test_withdraw();
    test_boundaries();
    test_reset_in_service();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
